// File: rtl/nibble_buffer.sv
// nibble_buffer: serializes a 4*N_NIBBLES-bit word into 4-bit nibbles,
// most-significant first. Each nibble is handed over with a valid/next
// handshake. A one-word pending slot lets frames run back-to-back.
// Optional feature macro: NIBBLE_BUFFER_PARITY_EN appends one trailing
// nibble per frame, equal to the XOR of all data nibbles.
module nibble_buffer #(
  parameter int N_NIBBLES = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*N_NIBBLES-1:0] in,
  input  logic                   load,
  output logic                   ready,
  input  logic                   next,
  output logic [3:0]             out,
  output logic                   valid,
  output logic                   first,
  output logic                   last
);

  localparam int W = 4 * N_NIBBLES;
`ifdef NIBBLE_BUFFER_PARITY_EN
  localparam int FRAME_LEN = N_NIBBLES + 1;
`else
  localparam int FRAME_LEN = N_NIBBLES;
`endif
  localparam int SH_W  = 4 * FRAME_LEN;
  localparam int PTR_W = $clog2(FRAME_LEN);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_reg;
  logic [SH_W-1:0]  sh_reg;      // nibbles not yet shown, MS-aligned
  logic [PTR_W-1:0] ptr_reg;     // index of the nibble currently on out
  logic [W-1:0]     pend_reg;
  logic             pend_v_reg;
  logic [3:0]       out_reg;
  logic             first_reg;
  logic             last_reg;

  // Full frame images (data nibbles, plus parity nibble when enabled)
  logic [SH_W-1:0]  in_frame;
  logic [SH_W-1:0]  pend_frame;
  logic [SH_W-1:0]  load_frame;

`ifdef NIBBLE_BUFFER_PARITY_EN
  logic [N_NIBBLES:0][3:0] in_par_chain;
  logic [N_NIBBLES:0][3:0] pend_par_chain;

  assign in_par_chain[0]   = 4'h0;
  assign pend_par_chain[0] = 4'h0;

  genvar gi;
  generate
    for (gi = 0; gi < N_NIBBLES; gi++) begin : g_parity
      assign in_par_chain[gi+1]   = in_par_chain[gi]   ^ in[4*gi +: 4];
      assign pend_par_chain[gi+1] = pend_par_chain[gi] ^ pend_reg[4*gi +: 4];
    end
  endgenerate

  assign in_frame   = {in, in_par_chain[N_NIBBLES]};
  assign pend_frame = {pend_reg, pend_par_chain[N_NIBBLES]};
`else
  assign in_frame   = in;
  assign pend_frame = pend_reg;
`endif

  // A queued word always takes precedence over the input port on reload
  assign load_frame = pend_v_reg ? pend_frame : in_frame;

  logic accept;
  logic at_last;

  assign ready   = ~pend_v_reg;
  assign accept  = load & ready;
  assign at_last = (ptr_reg == '0);

  assign out   = out_reg;
  assign valid = (state_reg == SEND);
  assign first = first_reg;
  assign last  = last_reg;

  // Frame sequencing, shift datapath and pending slot with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      sh_reg     <= '0;
      ptr_reg    <= LAST_PTR;
      pend_reg   <= '0;
      pend_v_reg <= 1'b0;
      out_reg    <= 4'h0;
      first_reg  <= 1'b0;
      last_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg <= SEND;
            out_reg   <= load_frame[SH_W-1 -: 4];
            sh_reg    <= {load_frame[SH_W-5:0], 4'h0};
            ptr_reg   <= LAST_PTR;
            first_reg <= 1'b1;
            last_reg  <= 1'b0;
          end
        end
        SEND: begin
          if (next && at_last) begin
            if (pend_v_reg || accept) begin
              // Chain straight into the next frame with no idle cycle
              out_reg    <= load_frame[SH_W-1 -: 4];
              sh_reg     <= {load_frame[SH_W-5:0], 4'h0};
              ptr_reg    <= LAST_PTR;
              first_reg  <= 1'b1;
              last_reg   <= 1'b0;
              pend_v_reg <= 1'b0;
            end else begin
              state_reg <= IDLE;
              out_reg   <= 4'h0;
              first_reg <= 1'b0;
              last_reg  <= 1'b0;
            end
          end else begin
            if (next) begin
              out_reg   <= sh_reg[SH_W-1 -: 4];
              sh_reg    <= sh_reg << 4;
              ptr_reg   <= ptr_reg - PTR_W'(1);
              first_reg <= 1'b0;
              last_reg  <= (ptr_reg == PTR_W'(1));
            end
            if (accept) begin
              pend_reg   <= in;
              pend_v_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
